// File: rtl/hazard_scheduler.sv
// Pipeline hazard scheduler: operand forwarding, load-use / memory-wait stalls,
// branch flushes, and saturating stall/flush event counters.
module hazard_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  Rs1D,
    input  logic [3:0]  Rs2D,
    input  logic [3:0]  Rs1E,
    input  logic [3:0]  Rs2E,
    input  logic [3:0]  RdE,
    input  logic [3:0]  RdM,
    input  logic [3:0]  RdW,
    input  logic        regWriteE,
    input  logic        regWriteM,
    input  logic        regWriteW,
    input  logic [1:0]  resultSrcE,
    input  logic        pcSrcE,
    input  logic        memReqM,
    input  logic        memReadyM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic [1:0]  forwardAE,
    output logic [1:0]  forwardBE,
    output logic [15:0] stallCnt,
    output logic [15:0] flushCnt,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W = 16;
    localparam logic [1:0]  SRC_LOAD = 2'b01;
    localparam logic [1:0]  FWD_REG  = 2'b00;
    localparam logic [1:0]  FWD_M    = 2'b10;
    localparam logic [1:0]  FWD_W    = 2'b01;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        MEMWAIT = 2'b10,
        FLUSH   = 2'b11
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   ld_haz;
    logic   mem_wait;

    assign mem_wait = memReqM & ~memReadyM;
    assign ld_haz   = (resultSrcE == SRC_LOAD) && regWriteE &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign state    = cur_state;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and stall/flush decode; everything held quiet during reset
    always_comb begin
        nxt_state = cur_state;
        stallF    = 1'b0;
        stallD    = 1'b0;
        stallE    = 1'b0;
        stallM    = 1'b0;
        flushD    = 1'b0;
        flushE    = 1'b0;
        if (rst) begin
            case (cur_state)
                RUN: begin
                    if (mem_wait) begin
                        {stallF, stallD, stallE, stallM} = 4'b1111;
                        nxt_state = MEMWAIT;
                    end else if (pcSrcE) begin
                        flushD    = 1'b1;
                        flushE    = 1'b1;
                        nxt_state = FLUSH;
                    end else if (ld_haz) begin
                        stallF    = 1'b1;
                        stallD    = 1'b1;
                        flushE    = 1'b1;
                        nxt_state = LDSTALL;
                    end
                end
                LDSTALL: begin
                    // Hazard already resolved; a repeat ldHaz is not re-taken
                    if (mem_wait) begin
                        nxt_state = MEMWAIT;
                    end else if (pcSrcE) begin
                        nxt_state = FLUSH;
                    end else begin
                        nxt_state = RUN;
                    end
                end
                MEMWAIT: begin
                    // Execute is frozen, so branches and load-use are ignored here
                    if (mem_wait) begin
                        {stallF, stallD, stallE, stallM} = 4'b1111;
                    end else begin
                        nxt_state = RUN;
                    end
                end
                FLUSH: begin
                    flushD    = 1'b1;
                    nxt_state = mem_wait ? MEMWAIT : RUN;
                end
                default: nxt_state = RUN;
            endcase
        end
    end

    // Operand forwarding; the younger M-stage result wins over W
    always_comb begin
        forwardAE = FWD_REG;
        forwardBE = FWD_REG;
        if (rst) begin
            if (regWriteM && (RdM == Rs1E)) begin
                forwardAE = FWD_M;
            end else if (regWriteW && (RdW == Rs1E)) begin
                forwardAE = FWD_W;
            end
            if (regWriteM && (RdM == Rs2E)) begin
                forwardBE = FWD_M;
            end else if (regWriteW && (RdW == Rs2E)) begin
                forwardBE = FWD_W;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (stallF && (stallCnt != {CNT_W{1'b1}})) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
            if ((flushD || flushE) && (flushCnt != {CNT_W{1'b1}})) begin
                flushCnt <= flushCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed scenarios plus random traffic
// checked against a behavioural model of the scheduling rules.
module tb_hazard_scheduler;

    localparam int S_RUN = 0;
    localparam int S_LD  = 1;
    localparam int S_MW  = 2;
    localparam int S_FL  = 3;
    localparam int SAT   = 65535;

    typedef struct packed {
        logic [3:0]  st;   // stallF, stallD, stallE, stallM
        logic [1:0]  fl;   // flushD, flushE
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [1:0]  state;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        regWriteE, regWriteM, regWriteW;
    logic [1:0]  resultSrcE;
    logic        pcSrcE, memReqM, memReadyM;
    logic        stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0]  forwardAE, forwardBE;
    logic [15:0] stallCnt, flushCnt;
    logic [1:0]  state;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   m_state = S_RUN;
    int   m_sc = 0;
    int   m_fc = 0;

    hazard_scheduler dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
        .resultSrcE(resultSrcE), .pcSrcE(pcSrcE),
        .memReqM(memReqM), .memReadyM(memReadyM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallCnt(stallCnt), .flushCnt(flushCnt), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] fwd(input logic [3:0] rs);
        if (regWriteM && RdM == rs) return 2'b10;
        if (regWriteW && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {regWriteE, regWriteM, regWriteW, pcSrcE, memReqM, memReadyM} = '0;
        resultSrcE = 2'b00;
    endtask

    // Predict this cycle's response from the rules, queue it, advance the model
    task automatic tick();
        exp_t e;
        logic mw, br, ld;
        int   nxt;
        e  = '0;
        mw = memReqM && !memReadyM;
        br = pcSrcE;
        ld = (resultSrcE == 2'b01) && regWriteE && (RdE == Rs1D || RdE == Rs2D);
        e.state = 2'(m_state);
        e.sc    = 16'(m_sc);
        e.fc    = 16'(m_fc);
        nxt     = S_RUN;
        if (rst) begin
            e.fa = fwd(Rs1E);
            e.fb = fwd(Rs2E);
            if (m_state == S_RUN) begin
                if (mw)      begin e.st = 4'b1111; nxt = S_MW; end
                else if (br) begin e.fl = 2'b11; nxt = S_FL; end
                else if (ld) begin e.st = 4'b1100; e.fl = 2'b01; nxt = S_LD; end
            end else if (m_state == S_LD) begin
                nxt = mw ? S_MW : (br ? S_FL : S_RUN);
            end else if (m_state == S_MW) begin
                if (mw) begin e.st = 4'b1111; nxt = S_MW; end
            end else begin
                e.fl = 2'b10;
                nxt  = mw ? S_MW : S_RUN;
            end
        end
        q.push_back(e);
        if (!rst) begin
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (e.st[3] && m_sc < SAT) m_sc++;
            if (e.fl != 2'b00 && m_fc < SAT) m_fc++;
        end
        m_state = nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s vec=%0d got=%0h expected=%0h", name, n_vec, act, exp);
        end
    endtask

    function automatic logic [3:0] rnd_reg();
        if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 3));
    endfunction

    // Monitor: every cycle the DUT presents a response; compare against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                chk("stall", int'({stallF, stallD, stallE, stallM}), int'(e.st));
                chk("flush", int'({flushD, flushE}), int'(e.fl));
                chk("forwardAE", int'(forwardAE), int'(e.fa));
                chk("forwardBE", int'(forwardBE), int'(e.fb));
                chk("state", int'(state), int'(e.state));
                chk("stallCnt", int'(stallCnt), int'(e.sc));
                chk("flushCnt", int'(flushCnt), int'(e.fc));
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state with outputs forced quiet despite matching operands
        regWriteM = 1'b1;
        tick();
        rst = 1'b1;
        clear_inputs();

        // Forwarding priority M over W, then W alone
        RdM = 4'd3; regWriteM = 1'b1; RdW = 4'd3; regWriteW = 1'b1; Rs1E = 4'd3;
        tick();
        regWriteM = 1'b0;
        tick();
        RdW = 4'd15; Rs2E = 4'd15;
        tick();
        clear_inputs();

        // Load-use: one stall cycle, LDSTALL ignores the still-present hazard
        do_reset();
        resultSrcE = 2'b01; regWriteE = 1'b1; RdE = 4'd5; Rs2D = 4'd5;
        tick();
        tick();
        clear_inputs();
        tick();

        // Branch: RUN flush, FLUSH ignores a second pcSrcE
        do_reset();
        pcSrcE = 1'b1;
        tick();
        tick();
        pcSrcE = 1'b0;
        tick();
        tick();

        // Memory wait for three cycles
        do_reset();
        memReqM = 1'b1; memReadyM = 1'b0;
        repeat (3) tick();
        memReadyM = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Simultaneous events: memory wait wins, branch/load ignored in MEMWAIT
        do_reset();
        memReqM = 1'b1; pcSrcE = 1'b1;
        resultSrcE = 2'b01; regWriteE = 1'b1; RdE = 4'd7; Rs1D = 4'd7;
        tick();
        memReadyM = 1'b1;
        tick();
        clear_inputs();
        tick();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 63) != 0);
            Rs1D       = rnd_reg(); Rs2D = rnd_reg();
            Rs1E       = rnd_reg(); Rs2E = rnd_reg();
            RdE        = rnd_reg(); RdM  = rnd_reg(); RdW = rnd_reg();
            regWriteE  = 1'($urandom_range(0, 1));
            regWriteM  = 1'($urandom_range(0, 1));
            regWriteW  = 1'($urandom_range(0, 1));
            resultSrcE = 2'($urandom_range(0, 3));
            pcSrcE     = ($urandom_range(0, 7) == 0);
            memReqM    = ($urandom_range(0, 3) == 0);
            memReadyM  = ($urandom_range(0, 2) != 0);
            tick();
        end
        rst = 1'b1;
        clear_inputs();

        // Counter saturation under a long memory wait, then reset inside MEMWAIT
        do_reset();
        memReqM = 1'b1; memReadyM = 1'b0;
        repeat (65540) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        clear_inputs();
        tick();

        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
